cp0_int_ctrl: RTL and testbench

Interrupt responder for the five-stage core: latches three external interrupt lines, applies per-source masks and a global enable, arbitrates by fixed priority with nesting, and saves/restores return PCs on a 3-entry EPC stack. It drives the `int`/`ints`/`irs` inputs of the control decoder and consumes the decoder's `cp0_w_en`/`cp0_w_data` writes and `eret` retire. It sits beside the EX stage and redirects fetch on interrupt entry and return.

---
 rtl/cp0_pkg.sv | 16 +
 rtl/cp0_prio_enc.sv | 17 +
 rtl/cp0_int_ctrl.sv | 100 ++++++++++
 tb/tb_cp0_int_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 interrupt responder.
package cp0_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } cp0_state_t;

    localparam int N_SRC      = 3;
    localparam int CP0_WEN_IE = 3;
    localparam logic [1:0] SRC_0 = 2'd0;
    localparam logic [1:0] SRC_1 = 2'd1;
    localparam logic [1:0] SRC_2 = 2'd2;

endpackage

// File: rtl/cp0_prio_enc.sv
// Fixed-priority encoder over three request bits; bit 2 wins.
module cp0_prio_enc
    import cp0_pkg::*;
(
    input  logic [N_SRC-1:0] bits,
    output logic [1:0]       idx,
    output logic             valid
);

    always_comb begin
        idx   = SRC_0;
        valid = |bits;
        if (bits[2])      idx = SRC_2;
        else if (bits[1]) idx = SRC_1;
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// Interrupt responder: edge-latched requests, masked fixed-priority nesting,
// per-source EPC slots and a one-cycle fetch redirect on entry and return.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [PC_W-1:0] VEC_STRIDE = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       irq_in,
    input  logic [PC_W-1:0]  pc_cur,
    input  logic             pipe_valid,
    input  logic             eret,
    input  logic [3:0]       cp0_w_en,
    input  logic [3:0]       cp0_w_data,
    output logic             int_take,
    output logic [2:0]       ints,
    output logic [2:0]       irs,
    output logic             cp0_w_collision,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [PC_W-1:0]  epc
);

    cp0_state_t      state, state_n;
    logic [2:0]      irq_q, pending, mask, above, pending_n, irs_n;
    logic            ie;
    logic [PC_W-1:0] epc_stack [N_SRC];
    logic [1:0]      sel, level;
    logic            sel_valid, level_valid, ret_take;

    cp0_prio_enc u_sel_enc   (.bits(ints), .idx(sel),   .valid(sel_valid));
    cp0_prio_enc u_level_enc (.bits(irs),  .idx(level), .valid(level_valid));

    // Only sources strictly above the current in-service level may preempt.
    always_comb begin
        above = 3'b111;
        if (level_valid) begin
            case (level)
                SRC_0:   above = 3'b110;
                SRC_1:   above = 3'b100;
                default: above = 3'b000;
            endcase
        end
    end

    assign ints            = pending & mask & above;
    assign cp0_w_collision = |cp0_w_en;
    assign int_take        = (state == RUN) && ie && sel_valid && pipe_valid
                             && !eret && !cp0_w_collision;
    assign ret_take        = (state == RUN) && eret && level_valid;
    assign redirect        = (state != RUN);
    assign epc             = level_valid ? epc_stack[level] : '0;

    always_comb begin
        state_n   = RUN;
        pending_n = pending;
        irs_n     = irs;
        if (int_take) begin
            state_n        = ENTER;
            pending_n[sel] = 1'b0;
            irs_n[sel]     = 1'b1;
        end else if (ret_take) begin
            state_n      = RETURN;
            irs_n[level] = 1'b0;
        end
        // A fresh edge re-arms the source even if it is being taken now.
        pending_n = pending_n | (irq_in & ~irq_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            irq_q       <= '0;
            pending     <= '0;
            irs         <= '0;
            mask        <= '0;
            ie          <= 1'b0;
            redirect_pc <= '0;
            for (int i = 0; i < N_SRC; i++) epc_stack[i] <= '0;
        end else begin
            state   <= state_n;
            irq_q   <= irq_in;
            pending <= pending_n;
            irs     <= irs_n;
            for (int i = 0; i < N_SRC; i++)
                if (cp0_w_en[i]) mask[i] <= cp0_w_data[i];
            if (cp0_w_en[CP0_WEN_IE]) ie <= cp0_w_data[CP0_WEN_IE];
            if (int_take) begin
                epc_stack[sel] <= pc_cur;
                redirect_pc    <= VEC_BASE + PC_W'(sel) * VEC_STRIDE;
            end else if (ret_take) begin
                redirect_pc <= epc_stack[level];
            end
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: entry, nesting, blocking and reset cases.
module tb_cp0_int_ctrl;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  irq_in;
    logic [31:0] pc_cur;
    logic        pipe_valid, eret;
    logic [3:0]  cp0_w_en, cp0_w_data;
    logic        int_take, cp0_w_collision, redirect;
    logic [2:0]  ints, irs;
    logic [31:0] redirect_pc, epc;

    int checks = 0;
    int failures = 0;

    cp0_int_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .pc_cur(pc_cur),
        .pipe_valid(pipe_valid), .eret(eret), .cp0_w_en(cp0_w_en),
        .cp0_w_data(cp0_w_data), .int_take(int_take), .ints(ints), .irs(irs),
        .cp0_w_collision(cp0_w_collision), .redirect(redirect),
        .redirect_pc(redirect_pc), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let outputs and combinational terms settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
        settle();
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; pc_cur = '0; pipe_valid = 1'b0; eret = 1'b0;
        cp0_w_en = '0; cp0_w_data = '0;
        step(); step();
        chk("rst_redirect", redirect, 0);
        chk("rst_irs", irs, 0);
        chk("rst_epc", epc, 0);
        chk("rst_int", int_take, 0);
        chk("rst_rpc", redirect_pc, 0);
        rst_n = 1'b1;

        cp0_w_en = 4'b1111; cp0_w_data = 4'b1111; settle();
        chk("wr_collision", cp0_w_collision, 1);
        step();
        cp0_w_en = '0; settle();
        chk("no_collision", cp0_w_collision, 0);

        // single entry on source 0
        pc_cur = 32'h100; pipe_valid = 1'b1; irq_in = 3'b001; settle();
        chk("e0_int_N", int_take, 0);
        step();
        irq_in = 3'b000; settle();
        chk("e0_int_N1", int_take, 1);
        chk("e0_ints", ints, 3'b001);
        step();
        chk("e0_redirect", redirect, 1);
        chk("e0_rpc", redirect_pc, 32'h800);
        chk("e0_irs", irs, 3'b001);
        chk("e0_epc", epc, 32'h100);
        chk("e0_int_enter", int_take, 0);
        step();
        chk("e0_redirect_off", redirect, 0);

        // nest source 2 above source 0
        pc_cur = 32'h804; irq_in = 3'b100; step();
        irq_in = 3'b000; settle();
        chk("e2_ints", ints, 3'b100);
        chk("e2_int", int_take, 1);
        step();
        chk("e2_rpc", redirect_pc, 32'h900);
        chk("e2_irs", irs, 3'b101);
        chk("e2_epc", epc, 32'h804);
        step();

        // source 1 below current level stays blocked
        irq_in = 3'b010; step();
        irq_in = 3'b000; settle();
        chk("e1_blocked_ints", ints, 3'b000);
        chk("e1_blocked_int", int_take, 0);
        step();
        chk("e1_blocked_int2", int_take, 0);
        eret = 1'b1; settle();
        chk("eret_blocks_int", int_take, 0);
        step();
        eret = 1'b0; settle();
        chk("r2_redirect", redirect, 1);
        chk("r2_rpc", redirect_pc, 32'h804);
        chk("r2_irs", irs, 3'b001);
        chk("r2_epc", epc, 32'h100);
        chk("r2_no_int_in_return", int_take, 0);
        step();
        chk("e1_int_after_ret", int_take, 1);
        chk("e1_ints", ints, 3'b010);
        step();
        chk("e1_rpc", redirect_pc, 32'h880);
        chk("e1_irs", irs, 3'b011);
        step();
        chk("e1_epc", epc, 32'h804);
        do_eret();
        chk("r1_rpc", redirect_pc, 32'h804);
        chk("r1_irs", irs, 3'b001);
        step();

        // pipe_valid low, then CP0 write, each hold off the request
        irq_in = 3'b010; step();
        irq_in = 3'b000; pipe_valid = 1'b0; settle();
        for (int i = 0; i < 3; i++) begin
            chk("bubble_int", int_take, 0);
            step();
        end
        pipe_valid = 1'b1; cp0_w_en = 4'b1000; cp0_w_data = 4'b1000; settle();
        chk("wr_int", int_take, 0);
        step();
        cp0_w_en = '0; pc_cur = 32'h200; settle();
        chk("late_int", int_take, 1);
        step();
        chk("late_rpc", redirect_pc, 32'h880);
        chk("late_irs", irs, 3'b011);
        step();

        // eret wins over a coincident eligible request
        irq_in = 3'b100; step();
        irq_in = 3'b000; eret = 1'b1; settle();
        chk("co_ints", ints, 3'b100);
        chk("co_int", int_take, 0);
        step();
        eret = 1'b0; settle();
        chk("co_ret_rpc", redirect_pc, 32'h200);
        chk("co_ret_irs", irs, 3'b001);
        chk("co_ret_int", int_take, 0);
        step();
        chk("co_entry_int", int_take, 1);
        step();
        chk("co_entry_rpc", redirect_pc, 32'h900);
        chk("co_entry_irs", irs, 3'b101);
        step();
        do_eret(); step();
        do_eret(); step();
        chk("drain_irs", irs, 3'b000);
        chk("drain_epc", epc, 0);

        // eret with nothing in service
        do_eret();
        chk("idle_eret_redirect", redirect, 0);

        // reset during ENTER, with source 1 also pending
        irq_in = 3'b001; step();
        irq_in = 3'b010; settle();
        chk("pre_rst_int", int_take, 1);
        step();
        irq_in = 3'b000;
        chk("pre_rst_redirect", redirect, 1);
        rst_n = 1'b0; step();
        rst_n = 1'b1; settle();
        chk("rst_mid_redirect", redirect, 0);
        chk("rst_mid_irs", irs, 3'b000);
        cp0_w_en = 4'b1000; cp0_w_data = 4'b1000; step();
        cp0_w_en = '0; irq_in = 3'b001; step();
        irq_in = 3'b000; settle();
        chk("rst_mask_cleared", ints, 3'b000);
        chk("rst_mask_int", int_take, 0);
        cp0_w_en = 4'b0010; cp0_w_data = 4'b0010; step();
        cp0_w_en = '0; settle();
        chk("rst_pending_cleared", ints, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
